monitor_comparador: RTL
=======================

MONITOR_COMPARADOR -- requirements
Module: monitor_comparador

Interface
REQ-001 Parameter ANCHO, default 8, data width of A/B and of mayor.
REQ-002 Parameter UMBRAL, default 3, consecutive-sample count for alarm set/clear; legal range 1..15.
REQ-003 Parameter ANCHO_CNT, default 8, width of each event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 valid  input  1  comparator result and operands are valid this cycle.
REQ-007 A  input  ANCHO  operand A, as presented to the upstream comparator.
REQ-008 B  input  ANCHO  operand B, as presented to the upstream comparator.
REQ-009 q  input  1  comparator equal flag: 1 = A==B.
REQ-010 q_lt  input  1  comparator less-than flag: 1 = A<B.
REQ-011 mayor  output  ANCHO  larger operand of the last valid legal sample.
REQ-012 cnt_gt, cnt_lt, cnt_eq, cnt_err  output  ANCHO_CNT each  saturating event counters.
REQ-013 alarma  output  1  sustained A<B condition.
REQ-014 estado  output  2  current FSM state code.

Function
REQ-015 A sample is taken only on a rising edge with valid=1; valid=0 cycles leave all registers unchanged, including run counters.
REQ-016 Classification: q=1,q_lt=0 -> EQ; q=0,q_lt=1 -> LT; q=0,q_lt=0 -> GT; q=1,q_lt=1 -> ERR.
REQ-017 Every sampled class increments its counter by 1 on the same edge; a counter at 2^ANCHO_CNT-1 holds.
REQ-018 mayor loads B on LT, A on GT or EQ, and holds on ERR; registered, latency one edge.
REQ-019 The module does not recompute the comparison; it uses q/q_lt as given.
REQ-020 FSM states: REPOSO=2'd0, CONTANDO=2'd1, ALARMA=2'd2; 2'd3 is unused and returns to REPOSO on the next edge.
REQ-021 REPOSO: an LT sample loads run=1; if UMBRAL=1, the next state is ALARMA, otherwise CONTANDO.
REQ-022 CONTANDO: an LT sample increments run; reaching UMBRAL moves to ALARMA; a GT/EQ/ERR sample clears run and returns to REPOSO.
REQ-023 ALARMA: a GT/EQ sample increments the clear-run count; an LT sample zeroes it; an ERR sample holds it.
REQ-024 ALARMA exits to REPOSO when the clear-run count reaches UMBRAL, clearing both run counters.
REQ-025 alarma is 1 exactly when estado==ALARMA; registered, no combinational path from inputs.
REQ-026 The ERR class never sets or clears the alarm by itself, except for breaking a CONTANDO run.
REQ-027 Run counters are 4 bits and never wrap, because UMBRAL<=15.

Reset
REQ-028 On rst=1, immediately and independent of clk: mayor=0, all counters=0, run counters=0, estado=REPOSO, alarma=0.
REQ-029 rst asserted mid-run discards any partial run.
REQ-030 The first valid sample after rst deasserts is processed normally on its edge.

Structure
REQ-031 Package comparador_pkg holds the state enum (REPOSO/CONTANDO/ALARMA), default ANCHO and default UMBRAL.
REQ-032 Package comparador_pkg holds the class encoding (EQ/LT/GT/ERR).
REQ-033 Sub-module contador_saturado (width parameter, inc input, async reset) is instantiated four times, once per event counter.
REQ-034 The FSM and the mayor register live in monitor_comparador.

Verification
REQ-035 Scenario 1: A=18,B=10,q=0,q_lt=0, valid for 1 cycle -> cnt_gt=1, mayor=18, estado=REPOSO.
REQ-036 Scenario 2: UMBRAL=3, A=10,B=18,q_lt=1, valid for 3 consecutive cycles -> estado 1,1,2; alarma=1 after the third edge; cnt_lt=3; mayor=18.
REQ-037 Scenario 3: from ALARMA, EQ(36,36), LT, EQ, EQ, EQ -> alarma is still 1 after the fourth sample and drops after the fifth; cnt_eq=4.
REQ-038 Scenario 4: q=1,q_lt=1 valid -> cnt_err=1, mayor unchanged, estado unchanged; the same sample in CONTANDO -> REPOSO.
REQ-039 Scenario 5: LT, LT, valid=0 for 5 cycles, LT -> ALARMA; idle cycles do not break the run.
REQ-040 Scenario 6: 300 GT samples with ANCHO_CNT=8 -> cnt_gt=255.
REQ-041 Scenario 7: rst pulsed between clock edges while in ALARMA -> all outputs 0 and estado=0 before the next edge.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared types for the comparator monitor: FSM state codes, sample classes
// and default parameter values.
package comparador_pkg;

    localparam int ANCHO_DEF  = 8;
    localparam int UMBRAL_DEF = 3;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONTANDO  = 2'd1,
        ALARMA    = 2'd2,
        NO_USADO  = 2'd3
    } estado_t;

    // The class code doubles as the index of its event counter.
    typedef enum logic [1:0] {
        CLS_EQ  = 2'd0,
        CLS_LT  = 2'd1,
        CLS_GT  = 2'd2,
        CLS_ERR = 2'd3
    } clase_t;

    function automatic clase_t clasificar(input logic q, input logic q_lt);
        clase_t c;
        case ({q, q_lt})
            2'b10:   c = CLS_EQ;
            2'b01:   c = CLS_LT;
            2'b00:   c = CLS_GT;
            default: c = CLS_ERR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/contador_saturado.sv
// Event counter that increments on inc and holds at its all-ones maximum.
module contador_saturado #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ANCHO-1:0] cnt
);

    localparam logic [ANCHO-1:0] MAXIMO = '1;

    logic [ANCHO-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != MAXIMO)) begin
            r_cnt <= r_cnt + ANCHO'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/monitor_comparador.sv
// Watches an upstream comparator's flags: counts each result class, keeps the
// larger operand and raises an alarm after UMBRAL consecutive A<B samples.
module monitor_comparador
    import comparador_pkg::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int UMBRAL    = UMBRAL_DEF,
    parameter int ANCHO_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [ANCHO-1:0]     A,
    input  logic [ANCHO-1:0]     B,
    input  logic                 q,
    input  logic                 q_lt,
    output logic [ANCHO-1:0]     mayor,
    output logic [ANCHO_CNT-1:0] cnt_gt,
    output logic [ANCHO_CNT-1:0] cnt_lt,
    output logic [ANCHO_CNT-1:0] cnt_eq,
    output logic [ANCHO_CNT-1:0] cnt_err,
    output logic                 alarma,
    output logic [1:0]           estado
);

    localparam logic [3:0] UMBRAL_4 = 4'(UMBRAL);

    clase_t               w_clase;
    logic                 w_inc [4];
    logic [ANCHO_CNT-1:0] w_cnt [4];

    estado_t          r_estado;
    estado_t          w_estado_next;
    logic [3:0]       r_run;
    logic [3:0]       w_run_next;
    logic [3:0]       r_clr;
    logic [3:0]       w_clr_next;
    logic [3:0]       w_run_inc;
    logic [3:0]       w_clr_inc;
    logic [ANCHO-1:0] r_mayor;
    logic             r_alarma;

    assign w_clase   = clasificar(q, q_lt);
    assign w_run_inc = r_run + 4'd1;
    assign w_clr_inc = r_clr + 4'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_contadores
            assign w_inc[gi] = valid && (w_clase == clase_t'(2'(gi)));

            contador_saturado #(
                .ANCHO (ANCHO_CNT)
            ) u_contador (
                .clk (clk),
                .rst (rst),
                .inc (w_inc[gi]),
                .cnt (w_cnt[gi])
            );
        end
    endgenerate

    assign cnt_eq  = w_cnt[CLS_EQ];
    assign cnt_lt  = w_cnt[CLS_LT];
    assign cnt_gt  = w_cnt[CLS_GT];
    assign cnt_err = w_cnt[CLS_ERR];

    always_comb begin
        w_estado_next = r_estado;
        w_run_next    = r_run;
        w_clr_next    = r_clr;
        case (r_estado)
            REPOSO: begin
                if (valid && (w_clase == CLS_LT)) begin
                    w_run_next    = 4'd1;
                    w_clr_next    = 4'd0;
                    w_estado_next = (UMBRAL_4 == 4'd1) ? ALARMA : CONTANDO;
                end
            end
            CONTANDO: begin
                if (valid) begin
                    if (w_clase == CLS_LT) begin
                        w_run_next = w_run_inc;
                        if (w_run_inc == UMBRAL_4) begin
                            w_estado_next = ALARMA;
                        end
                    end else begin
                        w_run_next    = 4'd0;
                        w_estado_next = REPOSO;
                    end
                end
            end
            ALARMA: begin
                // ERR neither advances nor breaks the clear run.
                if (valid) begin
                    if (w_clase == CLS_LT) begin
                        w_clr_next = 4'd0;
                    end else if (w_clase != CLS_ERR) begin
                        w_clr_next = w_clr_inc;
                        if (w_clr_inc == UMBRAL_4) begin
                            w_estado_next = REPOSO;
                            w_run_next    = 4'd0;
                            w_clr_next    = 4'd0;
                        end
                    end
                end
            end
            default: begin
                w_estado_next = REPOSO;
                w_run_next    = 4'd0;
                w_clr_next    = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= REPOSO;
            r_run    <= 4'd0;
            r_clr    <= 4'd0;
            r_alarma <= 1'b0;
        end else begin
            r_estado <= w_estado_next;
            r_run    <= w_run_next;
            r_clr    <= w_clr_next;
            r_alarma <= (w_estado_next == ALARMA);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mayor <= '0;
        end else if (valid) begin
            case (w_clase)
                CLS_LT:  r_mayor <= B;
                CLS_ERR: r_mayor <= r_mayor;
                default: r_mayor <= A;
            endcase
        end
    end

    assign mayor  = r_mayor;
    assign alarma = r_alarma;
    assign estado = r_estado;

endmodule
